// File: rtl/rf_pkg.sv
// Shared register-file constants and the dump-reader state encoding.
package rf_pkg;

  localparam int RF_NREG = 32;
  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } dr_state_t;

endpackage

// File: rtl/rf_dump_reader_if.sv
// Debug-side bundle of the register-file dump reader: start/range request,
// RF read port and the valid/ready word stream.
interface rf_dump_reader_if
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) ();

  logic          DRstart;
  logic [AW-1:0] DRfirst;
  logic [AW-1:0] DRlast;
  logic [AW-1:0] DRaddr;
  logic [DW-1:0] DRdata;
  logic          DRvalid;
  logic          DRready;
  logic [AW-1:0] DRindex;
  logic [DW-1:0] DRvalue;
  logic          DRend;
  logic          DRbusy;
  logic          DRhold;
  logic          DRdone;

  // The reader itself.
  modport slave (
    input  DRstart, DRfirst, DRlast, DRdata, DRready,
    output DRaddr, DRvalid, DRindex, DRvalue, DRend, DRbusy, DRhold, DRdone
  );

  // The debug host / register file / core side.
  modport master (
    output DRstart, DRfirst, DRlast, DRdata, DRready,
    input  DRaddr, DRvalid, DRindex, DRvalue, DRend, DRbusy, DRhold, DRdone
  );

endinterface

// File: rtl/rf_dump_reader.sv
// Walks a wrapping range of the register file through its combinational read
// port and streams each captured word out over valid/ready, holding writeback.
module rf_dump_reader
  import rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic             clk,
  input  logic             rst,
  rf_dump_reader_if.slave  dr
);

  dr_state_t     r_state;
  dr_state_t     w_next_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic [AW-1:0] r_index;
  logic [DW-1:0] r_value;
  logic          w_at_last;
  logic          w_xfer;
  logic [AW-1:0] w_idx_inc;

  assign w_at_last = (r_idx == r_last);
  assign w_xfer    = (r_state == SEND) && dr.DRready;
  assign w_idx_inc = AW'((32'(r_idx) + 32'd1) % NREG);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (dr.DRstart) w_next_state = READ;
      READ:    w_next_state = SEND;
      SEND:    if (dr.DRready) w_next_state = w_at_last ? DONE : READ;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_index <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          if (dr.DRstart) begin
            r_idx  <= dr.DRfirst;
            r_last <= dr.DRlast;
          end
        end
        READ: begin
          r_value <= dr.DRdata;
          r_index <= r_idx;
        end
        SEND: begin
          if (w_xfer && !w_at_last) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  // r_idx only moves on a start or a transfer, so it doubles as the held address.
  assign dr.DRaddr  = r_idx;
  assign dr.DRvalid = (r_state == SEND);
  assign dr.DRindex = r_index;
  assign dr.DRvalue = r_value;
  assign dr.DRend   = (r_state == SEND) && w_at_last;
  assign dr.DRbusy  = (r_state != IDLE);
  assign dr.DRhold  = (r_state != IDLE);
  assign dr.DRdone  = (r_state == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: RF + core model, scoreboard of expected words.
module tb_rf_dump_reader;
  import rf_pkg::*;

  typedef struct packed {
    logic [RF_AW-1:0] idx;
    logic [RF_DW-1:0] val;
    logic             is_last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [RF_DW-1:0] rf [RF_NREG];
  logic             wr_en;
  logic [RF_AW-1:0] wr_addr;
  logic [RF_DW-1:0] wr_data;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  rf_dump_reader_if ifc ();

  rf_dump_reader dut (
    .clk (clk),
    .rst (rst),
    .dr  (ifc.slave)
  );

  assign ifc.DRdata = rf[ifc.DRaddr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the core writes back here unless held.
  task automatic cycle();
    @(negedge clk);
    if (wr_en && !ifc.DRhold) rf[wr_addr] = wr_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, ifc.DRvalid, 0);
    check({tag, "_done"},  ifc.DRdone,  0);
    check({tag, "_busy"},  ifc.DRbusy,  0);
    check({tag, "_hold"},  ifc.DRhold,  0);
    check({tag, "_end"},   ifc.DRend,   0);
    check({tag, "_index"}, ifc.DRindex, 0);
    check({tag, "_value"}, ifc.DRvalue, 0);
    check({tag, "_addr"},  ifc.DRaddr,  0);
  endtask

  // One scan from fst to lst. Optional: stall on word stall_word for stall_len
  // cycles, poke a start mid-scan, attempt a core write, or abort at abort_word.
  task automatic run_scan(input logic [RF_AW-1:0] fst, input logic [RF_AW-1:0] lst,
                          input int stall_word, input int stall_len,
                          input bit poke, input bit do_write, input int abort_word);
    int               n;
    int               seen;
    int               cyc;
    int               stall_left;
    int               done_cyc;
    logic [RF_AW-1:0] i;

    sb.delete();
    i = fst;
    n = 0;
    forever begin
      sb.push_back('{idx: i, val: rf[i], is_last: (i == lst)});
      n++;
      if (i == lst) break;
      i = i + 1'b1;
    end

    ifc.DRfirst = fst;
    ifc.DRlast  = lst;
    ifc.DRstart = 1'b1;
    ifc.DRready = 1'b1;
    cycle();
    ifc.DRstart = 1'b0;
    ifc.DRfirst = ~fst;
    ifc.DRlast  = ~lst;
    check("start_busy",  ifc.DRbusy,  1);
    check("start_hold",  ifc.DRhold,  1);
    check("start_valid", ifc.DRvalid, 0);
    if (do_write) begin
      wr_en   = 1'b1;
      wr_addr = 5'd20;
      wr_data = 32'hdead_beef;
    end

    cyc        = 0;
    seen       = 0;
    stall_left = stall_len;
    done_cyc   = -1;
    while (cyc < 300) begin
      if (abort_word >= 0 && seen == abort_word && ifc.DRvalid) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          cycle();
          check("abort_no_done", ifc.DRdone, 0);
          check("abort_idle",    ifc.DRbusy, 0);
        end
        sb.delete();
        return;
      end
      if (ifc.DRdone) begin
        done_cyc = cyc;
        break;
      end
      if (ifc.DRvalid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          ifc.DRready = !(seen == stall_word && stall_left > 0);
          if (!ifc.DRready) stall_left--;
          check("word_index", ifc.DRindex, sb[0].idx);
          check("word_value", ifc.DRvalue, sb[0].val);
          check("word_end",   ifc.DRend,   sb[0].is_last);
          check("word_addr",  ifc.DRaddr,  sb[0].idx);
          if (ifc.DRready) begin
            void'(sb.pop_front());
            seen++;
          end
        end
      end
      if (poke && seen == 2) begin
        ifc.DRstart = 1'b1;
        ifc.DRfirst = 5'd3;
        ifc.DRlast  = 5'd3;
      end else begin
        ifc.DRstart = 1'b0;
      end
      cycle();
      cyc++;
    end

    ifc.DRstart = 1'b0;
    ifc.DRready = 1'b1;
    check("done_cycle",   done_cyc,    2 * n + stall_len);
    check("sb_drained",   sb.size(),   0);
    check("done_busy",    ifc.DRbusy,  1);
    check("done_novalid", ifc.DRvalid, 0);
    cycle();
    check("idle_done",  ifc.DRdone, 0);
    check("idle_busy",  ifc.DRbusy, 0);
    check("idle_hold",  ifc.DRhold, 0);
    wr_en = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < RF_NREG; r++) rf[r] = (r == 0) ? '0 : RF_DW'(r + 100);
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    ifc.DRstart = 1'b0;
    ifc.DRfirst = '0;
    ifc.DRlast  = '0;
    ifc.DRready = 1'b1;

    #2 check_reset_outputs("por");
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("post_reset_busy", ifc.DRbusy, 0);

    // Full range with a blocked core write to R20 during the scan.
    run_scan(5'd0, 5'd31, -1, 0, 1'b0, 1'b1, -1);
    rf[20] = 32'd120;

    run_scan(5'd30, 5'd1, -1, 0, 1'b0, 1'b0, -1);
    run_scan(5'd7,  5'd7, -1, 0, 1'b0, 1'b0, -1);
    run_scan(5'd0,  5'd5,  3, 5, 1'b0, 1'b0, -1);
    run_scan(5'd10, 5'd14, -1, 0, 1'b1, 1'b0, -1);
    run_scan(5'd0,  5'd31, -1, 0, 1'b0, 1'b0, 10);
    run_scan(5'd28, 5'd3, -1, 0, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Sequential reader for the register file's combinational read port, driven from the debug side of the monocycle processor. On a start pulse it walks a wrapping address range of the 32-entry register file, captures each word and streams it out one at a time over a valid/ready handshake. It also raises a hold signal so the core can freeze writeback during the scan, giving a coherent snapshot. It replaces the per-cycle simulation dump with a synthesizable, back-pressurable stream.

## Interface
Parameters:
- NREG, 32, number of architectural registers
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- DRstart  in  1  start pulse; sampled only in IDLE
- DRfirst  in  AW  first register index; captured with DRstart
- DRlast  in  AW  last register index; captured with DRstart
- DRaddr  out  AW  read address to register file read port
- DRdata  in  DW  combinational read data from register file
- DRvalid  out  1  output word valid
- DRready  in  1  consumer accepts word
- DRindex  out  AW  register index of current output word
- DRvalue  out  DW  captured register value
- DRend  out  1  current output word is the last of the range
- DRbusy  out  1  scan in progress (state != IDLE)
- DRhold  out  1  request to stall writeback; equals DRbusy
- DRdone  out  1  one-cycle pulse after final transfer

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: DRstart=1 at an edge -> capture DRfirst into index, DRlast into end reg -> READ.
- READ: DRaddr = index; at next edge DRdata captured into DRvalue, index copied to DRindex -> SEND.
- SEND: DRvalid=1; DRvalue/DRindex/DRend stable until an edge with DRready=1 (transfer). On transfer: if index == end -> DONE, else index = (index+1) mod NREG -> READ. No transfer -> remain in SEND.
- DONE: DRdone=1 for exactly one cycle -> IDLE.
- Range wraps modulo NREG: first=30, last=1 -> indices 30,31,0,1. first==last -> single word. Full range: first=0,last=31 (or first=k, last=k-1).
- DRstart while not IDLE ignored; DRfirst/DRlast changes mid-scan ignored.
- Register 0 read and reported like any other index (value comes from read port).
- DRaddr outside READ holds the last driven index (don't-care for RF, but defined).
- Index arithmetic AW bits, natural wrap; no comparison beyond equality with end.

## Timing
- Reset (async, immediate): state IDLE, DRvalid=0, DRdone=0, DRbusy=DRhold=0, DRend=0, DRindex=0, DRvalue=0, DRaddr=0.
- Reset mid-scan aborts; no DRdone issued; first cycle after reset release is IDLE.
- Start at edge e0 -> READ in cycle after e0; DRvalid high after e1.
- With DRready held 1: one word per 2 cycles; word k transferred at edge e(2k+2); DONE cycle follows last transfer; full 32-word scan asserts DRdone in cycle after e64, IDLE after e65.
- DRhold high from cycle after e0 through DONE inclusive; RF writes at negedge are blocked by core while DRhold=1, so READ-cycle data is stable at capture edge.
- DRstart in the DONE cycle ignored; earliest accepted restart is the IDLE cycle after.

## Structure
- Shared package rf_pkg: RF_NREG, RF_AW, RF_DW constants; dr_state_t enum (IDLE, READ, SEND, DONE).
- Single module; index/wrap counter inline (no sub-module needed). Output capture register and FSM in one always block with async reset.

## Test plan
- Bench RF model R[i]=i+100 (R0=0); start first=0,last=31, DRready=1 -> 32 words, DRindex 0..31, DRvalue 0,101..131, DRend only on index 31, DRdone after e64.
- Wrap: first=30,last=1, ready=1 -> indices 30,31,0,1 values 130,131,0,101; DRend on index 1.
- Single: first=last=7 -> one word 107 with DRend=1, DRdone next cycle.
- Backpressure: ready low 5 cycles on word 3 -> DRvalid held, DRvalue=103 stable, no index advance; resumes on ready.
- Start ignored while busy, and rst asserted mid-scan at word 10 -> outputs to reset values immediately, no DRdone; fresh start afterwards completes normally.
- Bench attempts RF write while DRhold=1 is suppressed by core model -> snapshot values match pre-scan contents.
